seq_alu: RTL and testbench



---
 rtl/seq_alu_pkg.sv | 34 +++
 rtl/alu_muldiv_iter.sv | 107 ++++++++++
 rtl/seq_alu.sv | 139 +++++++++++++
 tb/tb_seq_alu.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM states
// and a helper that tells multi-cycle opcodes apart from single-cycle ones.
package seq_alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Multiply and divide run through the shared iterative engine.
    function automatic logic isIterative(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared iterative engine: radix-2 Booth multiply and restoring divide on
// magnitudes, one iteration per step, with the sign fix-up for division.
// resultNext_o reflects the registers as they will be after the current
// step, so the caller can capture the final result on the last step edge.
module alu_muldiv_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 modeDiv_i,
    input  logic [WIDTH-1:0]     opA_i,
    input  logic [WIDTH-1:0]     opB_i,
    output logic                 lastStep_o,
    output logic [2*WIDTH-1:0]   resultNext_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LOAD_COUNT = CW'(WIDTH);

    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             booth_q, booth_d;
    logic [WIDTH-1:0] operand_q;
    logic [CW-1:0]    count_q;
    logic             negQuot_q, negRem_q;

    logic [WIDTH-1:0] absA, absB;
    logic [WIDTH:0]   mExt, partial, shifted, trial;
    logic [WIDTH-1:0] quotient, remainder;

    assign absA = opA_i[WIDTH-1] ? -opA_i : opA_i;
    assign absB = opB_i[WIDTH-1] ? -opB_i : opB_i;
    assign mExt = {operand_q[WIDTH-1], operand_q};

    // One iteration of either Booth multiply or restoring divide.
    always_comb begin
        acc_d   = acc_q;
        shift_d = shift_q;
        booth_d = booth_q;
        partial = acc_q;
        shifted = '0;
        trial   = '0;
        if (modeDiv_i) begin
            shifted = {acc_q[WIDTH-1:0], shift_q[WIDTH-1]};
            trial   = shifted - {1'b0, operand_q};
            if (!trial[WIDTH]) begin
                acc_d   = trial;
                shift_d = {shift_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d   = shifted;
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            case ({shift_q[0], booth_q})
                2'b01:   partial = acc_q + mExt;
                2'b10:   partial = acc_q - mExt;
                default: partial = acc_q;
            endcase
            acc_d   = {partial[WIDTH], partial[WIDTH:1]};
            shift_d = {partial[0], shift_q[WIDTH-1:1]};
            booth_d = shift_q[0];
        end
    end

    assign quotient     = negQuot_q ? -shift_d : shift_d;
    assign remainder    = negRem_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
    assign resultNext_o = modeDiv_i ? {quotient, remainder} : {acc_d[WIDTH-1:0], shift_d};
    assign lastStep_o   = (count_q == CW'(1));

    // Load operands (magnitudes and result signs for divide) or advance one step.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            acc_q     <= '0;
            shift_q   <= '0;
            booth_q   <= 1'b0;
            operand_q <= '0;
            count_q   <= '0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
        end else if (load_i) begin
            acc_q   <= '0;
            booth_q <= 1'b0;
            count_q <= LOAD_COUNT;
            if (modeDiv_i) begin
                shift_q   <= absA;
                operand_q <= absB;
                negQuot_q <= opA_i[WIDTH-1] ^ opB_i[WIDTH-1];
                negRem_q  <= opA_i[WIDTH-1];
            end else begin
                shift_q   <= opB_i;
                operand_q <= opA_i;
                negQuot_q <= 1'b0;
                negRem_q  <= 1'b0;
            end
        end else if (step_i) begin
            acc_q   <= acc_d;
            shift_q <= shift_d;
            booth_q <= booth_d;
            count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with a start/busy/done handshake. Simple ops finish in one
// cycle; multiply and divide iterate WIDTH cycles in alu_muldiv_iter.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [4:0]           opcode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   C,
    output logic                 div_by_zero,
    output logic                 illegal_op
);

    localparam int SHW = $clog2(WIDTH);

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 divByZero_q, divByZero_d;
    logic                 illegalOp_q, illegalOp_d;

    logic                 load, step, modeDiv, lastStep;
    logic [2*WIDTH-1:0]   iterResult;

    logic [SHW-1:0]       shAmt;
    logic [2*WIDTH-1:0]   rotRight, rotLeft;
    logic [WIDTH-1:0]     simpleLo, simpleHi;
    logic                 simpleDbz, simpleIll;

    assign shAmt    = B[SHW-1:0];
    assign rotRight = {A, A} >> shAmt;
    assign rotLeft  = {A, A} << shAmt;

    alu_muldiv_iter #(.WIDTH(WIDTH)) uIter (
        .clock        (clock),
        .clear        (clear),
        .load_i       (load),
        .step_i       (step),
        .modeDiv_i    (modeDiv),
        .opA_i        (A),
        .opB_i        (B),
        .lastStep_o   (lastStep),
        .resultNext_o (iterResult)
    );

    // Single-cycle results, including the divide-by-zero and illegal-opcode shortcuts.
    always_comb begin
        simpleLo  = '0;
        simpleHi  = '0;
        simpleDbz = 1'b0;
        simpleIll = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDI: simpleLo = A + B;
            OP_SUB:          simpleLo = A - B;
            OP_AND, OP_ANDI: simpleLo = A & B;
            OP_OR, OP_ORI:   simpleLo = A | B;
            OP_ROR:          simpleLo = rotRight[WIDTH-1:0];
            OP_ROL:          simpleLo = rotLeft[2*WIDTH-1:WIDTH];
            OP_SHR:          simpleLo = A >> shAmt;
            OP_SHRA:         simpleLo = $signed(A) >>> shAmt;
            OP_SHL:          simpleLo = A << shAmt;
            OP_NEG:          simpleLo = -A;
            OP_NOT:          simpleLo = ~A;
            OP_DIV: begin
                simpleHi  = '1;
                simpleLo  = A;
                simpleDbz = 1'b1;
            end
            OP_MUL:          simpleLo = '0;
            default:         simpleIll = 1'b1;
        endcase
    end

    // Next-state and datapath control; C and flags only change on entry to DONE.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        divByZero_d = divByZero_q;
        illegalOp_d = illegalOp_q;
        load        = 1'b0;
        step        = 1'b0;
        modeDiv     = (state_q == ST_DIV);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (isIterative(opcode) && (opcode == OP_MUL || B != '0)) begin
                        load    = 1'b1;
                        modeDiv = (opcode == OP_DIV);
                        state_d = (opcode == OP_DIV) ? ST_DIV : ST_MUL;
                    end else begin
                        result_d    = {simpleHi, simpleLo};
                        divByZero_d = simpleDbz;
                        illegalOp_d = simpleIll;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                step = 1'b1;
                if (lastStep) begin
                    result_d    = iterResult;
                    divByZero_d = 1'b0;
                    illegalOp_d = 1'b0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; clear aborts any operation in flight.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            divByZero_q <= 1'b0;
            illegalOp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            divByZero_q <= divByZero_d;
            illegalOp_q <= illegalOp_d;
        end
    end

    assign busy        = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign done        = (state_q == ST_DONE);
    assign C           = result_q;
    assign div_by_zero = divByZero_q;
    assign illegal_op  = illegalOp_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against a plain-arithmetic model.
module tb_seq_alu;

    localparam int W = 32;

    localparam logic [4:0] T_ADD  = 5'b00011;
    localparam logic [4:0] T_SUB  = 5'b00100;
    localparam logic [4:0] T_AND  = 5'b00101;
    localparam logic [4:0] T_OR   = 5'b00110;
    localparam logic [4:0] T_ROR  = 5'b00111;
    localparam logic [4:0] T_ROL  = 5'b01000;
    localparam logic [4:0] T_SHR  = 5'b01001;
    localparam logic [4:0] T_SHRA = 5'b01010;
    localparam logic [4:0] T_SHL  = 5'b01011;
    localparam logic [4:0] T_ADDI = 5'b01100;
    localparam logic [4:0] T_ANDI = 5'b01101;
    localparam logic [4:0] T_ORI  = 5'b01110;
    localparam logic [4:0] T_DIV  = 5'b01111;
    localparam logic [4:0] T_MUL  = 5'b10000;
    localparam logic [4:0] T_NEG  = 5'b10001;
    localparam logic [4:0] T_NOT  = 5'b10010;

    logic          clock = 1'b0;
    logic          clear;
    logic          start;
    logic [4:0]    opcode;
    logic [W-1:0]  A, B;
    logic          busy, done;
    logic [2*W-1:0] C;
    logic          div_by_zero, illegal_op;

    int            compareCount = 0;
    int            failCount = 0;
    logic [63:0]   lastExpC;
    logic          lastExpDbz, lastExpIll;
    logic [4:0]    opList [16];

    seq_alu #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .opcode      (opcode),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .C           (C),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Behavioural model: result, flags and done latency in cycles after the start cycle.
    function automatic void refModel(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [63:0] c, output logic dbz, output logic ill,
                                     output int lat);
        int          amt;
        longint      sa, sb, q, rm;
        logic [31:0] r;
        amt = int'(b % 32);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = 32'h0;
        c   = 64'h0;
        dbz = 1'b0;
        ill = 1'b0;
        lat = 1;
        case (op)
            T_ADD, T_ADDI: r = a + b;
            T_SUB:         r = a - b;
            T_AND, T_ANDI: r = a & b;
            T_OR, T_ORI:   r = a | b;
            T_ROR: begin r = a; repeat (amt) r = {r[0], r[31:1]}; end
            T_ROL: begin r = a; repeat (amt) r = {r[30:0], r[31]}; end
            T_SHR:         r = a >> amt;
            T_SHRA: begin r = a; repeat (amt) r = {r[31], r[31:1]}; end
            T_SHL:         r = a << amt;
            T_NEG:         r = 32'h0 - a;
            T_NOT:         r = ~a;
            default:       r = 32'h0;
        endcase
        c = {32'h0, r};
        if (op == T_MUL) begin
            c   = sa * sb;
            lat = W + 1;
        end else if (op == T_DIV) begin
            if (b == 32'h0) begin
                c   = {32'hFFFF_FFFF, a};
                dbz = 1'b1;
            end else begin
                q   = sa / sb;
                rm  = sa % sb;
                c   = {q[31:0], rm[31:0]};
                lat = W + 1;
            end
        end else if (!(op inside {T_ADD, T_SUB, T_AND, T_OR, T_ROR, T_ROL, T_SHR, T_SHRA,
                                  T_SHL, T_ADDI, T_ANDI, T_ORI, T_NEG, T_NOT})) begin
            ill = 1'b1;
        end
    endfunction

    // Issue one operation, optionally pulsing start while busy and in the done cycle.
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit noise, input bit startInDone);
        logic [63:0] expC;
        logic        expDbz, expIll;
        int          expLat, cycles, busyCycles;
        bit          sawDone;
        refModel(op, a, b, expC, expDbz, expIll, expLat);
        @(negedge clock);
        start = 1'b1; opcode = op; A = a; B = b;
        @(negedge clock);
        start = 1'b0;
        cycles = 1; busyCycles = 0; sawDone = 0;
        while (!sawDone && cycles <= 100) begin
            if (done) begin
                sawDone = 1;
            end else begin
                if (busy) busyCycles++;
                if (cycles == 1) begin
                    checkOutput("holdC", C, lastExpC);
                    checkOutput("holdDbz", 64'(div_by_zero), 64'(lastExpDbz));
                    checkOutput("holdIll", 64'(illegal_op), 64'(lastExpIll));
                end
                if (noise) start = 1'($urandom_range(0, 1));
                A = $urandom; B = $urandom; opcode = 5'($urandom);
                @(negedge clock);
                cycles++;
            end
        end
        start  = startInDone;
        opcode = opList[$urandom_range(0, 15)];
        A = $urandom; B = $urandom;
        checkOutput("latency", 64'(cycles), 64'(expLat));
        checkOutput("busyCycles", 64'(busyCycles), 64'(expLat - 1));
        checkOutput("C", C, expC);
        checkOutput("divByZero", 64'(div_by_zero), 64'(expDbz));
        checkOutput("illegalOp", 64'(illegal_op), 64'(expIll));
        checkOutput("busyAtDone", 64'(busy), 64'h0);
        @(negedge clock);
        start = 1'b0;
        checkOutput("donePulse", 64'(done), 64'h0);
        checkOutput("idleAfterDone", 64'(busy), 64'h0);
        checkOutput("heldC", C, expC);
        lastExpC = expC; lastExpDbz = expDbz; lastExpIll = expIll;
    endtask

    // Abort a multiply at iteration 10 and confirm nothing completes afterwards.
    task automatic clearMidMul();
        int doneSeen;
        doneSeen = 0;
        @(negedge clock);
        start = 1'b1; opcode = T_MUL; A = $urandom; B = $urandom;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        checkOutput("busyBeforeClear", 64'(busy), 64'h1);
        clear = 1'b1;
        #1;
        checkOutput("clearBusy", 64'(busy), 64'h0);
        checkOutput("clearDone", 64'(done), 64'h0);
        checkOutput("clearC", C, 64'h0);
        checkOutput("clearDbz", 64'(div_by_zero), 64'h0);
        checkOutput("clearIll", 64'(illegal_op), 64'h0);
        @(negedge clock);
        clear = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done) doneSeen++;
        end
        checkOutput("noDoneAfterClear", 64'(doneSeen), 64'h0);
        checkOutput("idleAfterClear", 64'(busy), 64'h0);
        lastExpC = 64'h0; lastExpDbz = 1'b0; lastExpIll = 1'b0;
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b;
        int          sel;
        opList = '{T_ADD, T_SUB, T_AND, T_OR, T_ROR, T_ROL, T_SHR, T_SHRA,
                   T_SHL, T_ADDI, T_ANDI, T_ORI, T_DIV, T_MUL, T_NEG, T_NOT};
        clear = 1'b1; start = 1'b0; opcode = 5'h0; A = '0; B = '0;
        #12;
        checkOutput("resetC", C, 64'h0);
        checkOutput("resetBusy", 64'(busy), 64'h0);
        checkOutput("resetDone", 64'(done), 64'h0);
        checkOutput("resetDbz", 64'(div_by_zero), 64'h0);
        checkOutput("resetIll", 64'(illegal_op), 64'h0);
        @(negedge clock);
        clear = 1'b0;
        lastExpC = 64'h0; lastExpDbz = 1'b0; lastExpIll = 1'b0;

        applyStimulus(T_ADD,  32'h7FFF_FFFF, 32'h1,         0, 0);
        applyStimulus(T_MUL,  32'hFFFF_FFFD, 32'h7,         1, 0);
        applyStimulus(T_DIV,  32'd100,       32'd7,         1, 1);
        applyStimulus(T_DIV,  32'hFFFF_FFF9, 32'd2,         0, 0);
        applyStimulus(T_DIV,  32'd5,         32'h0,         0, 1);
        applyStimulus(T_ADD,  32'd1,         32'd1,         0, 0);
        applyStimulus(T_SHRA, 32'h8000_00F1, 32'h0000_0024, 0, 1);
        applyStimulus(T_ROR,  32'h8000_00F1, 32'h0000_0024, 0, 0);
        applyStimulus(T_SHL,  32'h8000_00F1, 32'h0000_0024, 0, 0);
        applyStimulus(T_ROL,  32'h8000_00F1, 32'h0000_0024, 0, 0);
        applyStimulus(T_SHR,  32'h8000_00F1, 32'h0000_0024, 0, 0);
        applyStimulus(T_SHRA, 32'h8000_00F1, 32'hFFFF_FFE0, 0, 0);
        applyStimulus(T_ROR,  32'h8000_00F1, 32'h0000_0020, 0, 0);
        applyStimulus(T_NEG,  32'h0000_0005, 32'hDEAD_BEEF, 0, 0);
        applyStimulus(T_NOT,  32'h0F0F_1234, 32'h1234_5678, 0, 0);
        applyStimulus(T_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        applyStimulus(T_MUL,  32'h8000_0000, 32'h8000_0000, 0, 0);
        applyStimulus(T_DIV,  32'd9,         32'h0,         0, 0);
        applyStimulus(T_MUL,  32'd12345,     32'hFFFF_FF00, 1, 0);
        applyStimulus(5'b11111, 32'd3,       32'd4,         0, 0);
        applyStimulus(T_DIV,  32'd7,         32'h0,         0, 0);
        clearMidMul();
        applyStimulus(5'b11111, 32'd3,       32'd4,         0, 0);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 19);
            a = $urandom;
            b = $urandom;
            if (sel < 16) op = opList[sel];
            else op = 5'($urandom_range(19, 31));
            if ($urandom_range(0, 3) == 0) b = {{28{b[3]}}, b[3:0]};
            if (op == T_DIV && $urandom_range(0, 4) == 0) b = 32'h0;
            applyStimulus(op, a, b, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", compareCount, failCount);
        $finish;
    end

endmodule
